instruction_fetch_stage: RTL and testbench
==========================================

Name: instruction_fetch_stage

Overview:
Fetch stage directly upstream of the instruction memory. It owns the program counter, drives the word address to the combinational-read memory and captures the returned word. It buffers fetched {pc, instr} pairs in a 2-entry queue and presents them to decode over a valid/ready handshake. It handles branch/jump redirects, and halts on an all-zero word, since unprogrammed memory reads as zero.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
IMEM_DEPTH, 64, instruction memory depth in 32-bit words; used only by the optional bounds check.

Ports:
clk  input  1  rising-edge clock
reset  input  1  reset, asynchronous, active-high
imem_addr  output  32  byte address to instruction memory; equals pc_q; memory applies >>2 itself
imem_rdata  input  32  instruction word, combinational from imem_addr in the same cycle
redirect_valid  input  1  branch/jump taken this cycle
redirect_pc  input  32  redirect target (byte address)
out_valid  output  1  buffer head valid
out_ready  input  1  decode accepts head
out_pc  output  32  PC of head entry
out_instr  output  32  instruction of head entry
out_pc_plus4  output  32  out_pc + 4, modulo 2^32
halted  output  1  FSM in HALT
fault  output  1  bounds fault; tied 0 when the feature is absent

Behaviour:
- Reset (async assert, sync-style deassert into BOOT):
  - pc_q = RESET_PC; buffer count = 0; state = BOOT.
  - out_valid = 0, halted = 0, fault = 0, imem_addr = RESET_PC.
  - out_pc, out_instr and out_pc_plus4 are 0 while count = 0.
- FSM states: BOOT, FETCH, HALT.
  - BOOT: no fetch; unconditionally goes to FETCH next cycle. This gives one settle cycle after memory reset clears.
  - FETCH: a push occurs when count < 2, or when count = 2 and a pop happens this cycle.
    - On push: entry {pc_q, imem_rdata} is enqueued and pc_q <= pc_q + 4, wrapping modulo 2^32.
    - Sustained throughput is 1 instr/cycle with out_ready = 1.
  - FETCH -> HALT when a push would occur and imem_rdata == 32'h0. The zero word is not enqueued, pc_q holds, and halted = 1 from the next cycle.
  - HALT: no fetch. Buffered entries still drain normally. Exits only on redirect.
- Handshake:
  - Pop when out_valid && out_ready.
  - Head outputs are stable while out_valid = 1 and out_ready = 0.
  - out_valid = (count != 0), driven from registers only, with no combinational path from imem_rdata.
  - Entries are delivered in order.
- Redirect (highest priority, any state except BOOT):
  - pc_q <= {redirect_pc[31:2], 2'b00}; count <= 0; state <= FETCH; halted and fault clear.
  - No push that cycle.
  - A pop in the redirect cycle still counts as a completed transfer; flushing it is decode's responsibility.
- Simultaneous push and pop: count is unchanged, and the head advances.
- Full (count = 2), no pop: fetch stalls, pc_q holds, and imem_addr is stable.
- Redirect during BOOT is ignored.
- Reset mid-operation: immediately returns to reset values; all buffered entries are lost.

Optional Feature:
Macro FETCH_BOUNDS_CHECK_EN.
- Defined: in FETCH, if pc_q >= 4*IMEM_DEPTH, no push occurs; state -> HALT, and fault = 1 and halted = 1 from the next cycle. Redirect clears both.
- Not defined: no range check; fault is tied 0. Out-of-range addresses go to memory unchanged, which handles index wrap/aliasing.

Decomposition:
- Package rv_fetch_pkg:
  - XLEN = 32, INSTR_W = 32, FETCH_BUF_DEPTH = 2.
  - fetch_state_t enum {BOOT, FETCH, HALT}.
  - fetch_entry_t struct {pc, instr}.
  - ILLEGAL_ZERO_INSTR = 32'h0.
- Sub-module fetch_buffer: 2-entry synchronous FIFO of fetch_entry_t with push/pop/count, async reset. The top level holds the PC register and FSM.

Test Plan:
- Preload words 0x00500093, 0x00A00113, 0x002081B3 at addresses 0x0, 0x4, 0x8 (word 3 = 0), out_ready = 1:
  - out_valid first rises 2 cycles after reset deassert.
  - Outputs are (0x0, 0x00500093), (0x4, ...), (0x8, ...), then halted = 1 with imem_addr = 0xC.
- Backpressure:
  - Hold out_ready = 0 for 5 cycles: count saturates at 2, imem_addr holds at 0x8, and the head stays (0x0, 0x00500093).
  - Release: all three entries arrive in order with no duplicates.
- Redirect to 0x12 while 2 entries are buffered:
  - Next cycle count = 0, out_valid = 0, imem_addr = 0x10.
  - The next delivered entry has out_pc = 0x10.
- Redirect while halted: halted clears next cycle and fetch resumes at the target.
- Wrap: redirect to 0xFFFFFFFC with a nonzero word there. Entry pc = 0xFFFFFFFC, out_pc_plus4 = 0x0, next imem_addr = 0x0.
- With FETCH_BOUNDS_CHECK_EN and IMEM_DEPTH = 64, redirect to 0x100:
  - fault = 1 and halted = 1 next cycle, with nothing enqueued.
  - Assert reset mid-run: all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/rv_fetch_pkg.sv
// rtl/rv_fetch_pkg.sv - shared types and constants for the instruction fetch stage
//
// Purpose: datapath widths, fetch buffer depth, fetch FSM state encoding,
// the {pc, instr} buffer entry type and the all-zero halt word.
// Ports: none (package).
// Optional feature macro used by the fetch stage: FETCH_BOUNDS_CHECK_EN.

package rv_fetch_pkg;

  localparam int XLEN            = 32;
  localparam int INSTR_W         = 32;
  localparam int FETCH_BUF_DEPTH = 2;

  localparam logic [INSTR_W-1:0] ILLEGAL_ZERO_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - 2-entry in-order queue of fetched {pc, instr} pairs
//
// Purpose: holds fetched entries between the fetch stage and decode.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset, empties the queue
//   flush      in   synchronous empty (redirect); wins over push/pop
//   push       in   enqueue push_entry (caller guarantees room, or a pop this cycle)
//   push_entry in   entry to enqueue
//   pop        in   dequeue head (caller guarantees count != 0)
//   count      out  number of valid entries, 0..2
//   head       out  oldest entry, all zeros while empty

module fetch_buffer
  import rv_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t slots [FETCH_BUF_DEPTH];
  logic         wr_ptr;
  logic         rd_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int i = 0; i < FETCH_BUF_DEPTH; i++) begin
        slots[i] <= '0;
      end
    end else if (flush) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      // When full with a simultaneous pop, wr_ptr equals rd_ptr: the slot
      // being vacated is overwritten, which is safe because head is read
      // from the register value before this edge.
      if (push) begin
        slots[wr_ptr] <= push_entry;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head = (count != 2'd0) ? slots[rd_ptr] : '0;

endmodule

// File: rtl/instruction_fetch_stage.sv
// rtl/instruction_fetch_stage.sv - PC register, fetch FSM and decode-facing handshake
//
// Purpose: owns the program counter, reads the combinational instruction
// memory, queues {pc, instr} pairs in a 2-entry buffer and hands them to
// decode over valid/ready. Handles redirects and halts on an all-zero word.
// Optional feature: define FETCH_BOUNDS_CHECK_EN to halt with fault when
// pc_q >= 4*IMEM_DEPTH; otherwise fault is constant 0.
// Ports:
//   clk, reset               clock; asynchronous active-high reset
//   imem_addr                byte address to memory (= pc_q)
//   imem_rdata               word returned for imem_addr in the same cycle
//   redirect_valid/_pc       taken branch/jump and its byte target
//   out_valid/out_ready      head handshake with decode
//   out_pc/out_instr         head entry (zero while empty)
//   out_pc_plus4             out_pc + 4 (zero while empty)
//   halted                   FSM is in HALT
//   fault                    bounds fault

module instruction_fetch_stage
  import rv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 64
)(
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc_plus4,
  output logic        halted,
  output logic        fault
);

  localparam logic [XLEN-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

  if (IMEM_DEPTH < 1) begin : g_bad_depth
    $error("IMEM_DEPTH must be at least 1");
  end

  fetch_state_t    state_q;
  logic [XLEN-1:0] pc_q;
  logic            halted_q;
  logic            fault_q;

  logic [1:0]      count;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;
  logic            pop;
  logic            push;
  logic            flush;
  logic            slot_free;
  logic            zero_word;
  logic            bounds_err;
  logic            in_fetch;

  assign in_fetch  = (state_q == FETCH);
  assign pop       = out_valid && out_ready;
  // Space exists if not full, or if the head leaves this same cycle.
  assign slot_free = (count < 2'(FETCH_BUF_DEPTH)) || pop;
  assign zero_word = (imem_rdata == ILLEGAL_ZERO_INSTR);

`ifdef FETCH_BOUNDS_CHECK_EN
  localparam logic [XLEN:0] PC_LIMIT = (XLEN+1)'(4 * IMEM_DEPTH);
  assign bounds_err = in_fetch && ({1'b0, pc_q} >= PC_LIMIT);
`else
  assign bounds_err = 1'b0;
`endif

  // Redirect is ignored in BOOT; elsewhere it flushes and suppresses the push.
  assign flush = redirect_valid && (state_q != BOOT);
  assign push  = in_fetch && !redirect_valid && !bounds_err && slot_free && !zero_word;

  assign push_entry.pc    = pc_q;
  assign push_entry.instr = imem_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      case (state_q)
        BOOT: begin
          // One settle cycle after memory leaves reset.
          state_q <= FETCH;
        end
        default: begin
          if (redirect_valid) begin
            pc_q     <= redirect_pc & PC_ALIGN_MASK;
            state_q  <= FETCH;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
          end else if (state_q == FETCH) begin
            if (bounds_err) begin
              state_q  <= HALT;
              halted_q <= 1'b1;
              fault_q  <= 1'b1;
            end else if (slot_free) begin
              if (zero_word) begin
                // Unprogrammed memory: stop without enqueuing, pc holds.
                state_q  <= HALT;
                halted_q <= 1'b1;
              end else begin
                pc_q <= pc_q + 32'd4;
              end
            end
          end
        end
      endcase
    end
  end

  fetch_buffer u_fetch_buffer (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .count      (count),
    .head       (head)
  );

  assign imem_addr    = pc_q;
  assign out_valid    = (count != 2'd0);
  assign out_pc       = head.pc;
  assign out_instr    = head.instr;
  assign out_pc_plus4 = out_valid ? (head.pc + 32'd4) : 32'd0;
  assign halted       = halted_q;
  assign fault        = fault_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb/tb_instruction_fetch_stage.sv - directed self-checking bench for instruction_fetch_stage

module tb_instruction_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [31:0] out_pc_plus4;
  logic        halted;
  logic        fault;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [64];
  assign imem_rdata = mem[6'(imem_addr >> 2)];

  always #5 clk = ~clk;

  instruction_fetch_stage #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_DEPTH (64)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_pc_plus4   (out_pc_plus4),
    .halted         (halted),
    .fault          (fault)
  );

  localparam logic [31:0] I0 = 32'h0050_0093;
  localparam logic [31:0] I1 = 32'h00A0_0113;
  localparam logic [31:0] I2 = 32'h0020_81B3;
  localparam logic [31:0] I_AT_10 = 32'h0010_0013;
  localparam logic [31:0] I_TOP = 32'h0000_0013;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_program();
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0]  = I0;
    mem[1]  = I1;
    mem[2]  = I2;
    mem[4]  = I_AT_10;
    mem[63] = I_TOP;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic redirect_to(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc = target;
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", halted); end
    checks++; if (fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b exp=0", fault); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
    checks++; if ({out_pc, out_instr, out_pc_plus4} !== 96'h0) begin failures++; $display("FAIL reset_head got=%h/%h/%h exp=0", out_pc, out_instr, out_pc_plus4); end
  endtask

  task automatic test_stream();
    logic [31:0] epc [3];
    logic [31:0] ein [3];
    epc[0] = 32'h0; epc[1] = 32'h4; epc[2] = 32'h8;
    ein[0] = I0;    ein[1] = I1;    ein[2] = I2;
    out_ready = 1'b1;
    do_reset();
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_boot_valid got=%b exp=0", out_valid); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (out_valid !== 1'b1 || out_pc !== epc[i] || out_instr !== ein[i] || out_pc_plus4 !== epc[i] + 32'd4)
        begin failures++; $display("FAIL stream_entry%0d got=%b/%h/%h/%h exp=1/%h/%h/%h", i, out_valid, out_pc, out_instr, out_pc_plus4, epc[i], ein[i], epc[i] + 32'd4); end
    end
    step();
    checks++; if (out_valid !== 1'b0 || halted !== 1'b1 || imem_addr !== 32'hC)
      begin failures++; $display("FAIL stream_halt got=%b/%b/%h exp=0/1/c", out_valid, halted, imem_addr); end
    step();
    checks++; if (halted !== 1'b1 || imem_addr !== 32'hC || out_valid !== 1'b0)
      begin failures++; $display("FAIL stream_halt_hold got=%b/%h/%b exp=1/c/0", halted, imem_addr, out_valid); end
  endtask

  task automatic test_halt_redirect();
    out_ready = 1'b1;
    redirect_to(32'h0);
    checks++; if (halted !== 1'b0 || imem_addr !== 32'h0 || out_valid !== 1'b0)
      begin failures++; $display("FAIL halt_redir_clear got=%b/%h/%b exp=0/0/0", halted, imem_addr, out_valid); end
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== I0)
      begin failures++; $display("FAIL halt_redir_resume got=%b/%h/%h exp=1/0/%h", out_valid, out_pc, out_instr, I0); end
  endtask

  task automatic test_backpressure();
    logic [31:0] got_pc [8];
    logic [31:0] got_in [8];
    int n;
    n = 0;
    out_ready = 1'b0;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      step();
      if (c == 3) begin
        checks++; if (imem_addr !== 32'h8 || out_pc !== 32'h0 || out_instr !== I0)
          begin failures++; $display("FAIL bp_mid got=%h/%h/%h exp=8/0/%h", imem_addr, out_pc, out_instr, I0); end
      end
    end
    checks++; if (out_valid !== 1'b1 || imem_addr !== 32'h8 || out_pc !== 32'h0 || out_instr !== I0)
      begin failures++; $display("FAIL bp_hold got=%b/%h/%h/%h exp=1/8/0/%h", out_valid, imem_addr, out_pc, out_instr, I0); end
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (out_valid === 1'b1 && n < 8) begin
        got_pc[n] = out_pc;
        got_in[n] = out_instr;
        n++;
      end
      step();
    end
    checks++; if (n !== 3) begin failures++; $display("FAIL bp_count got=%0d exp=3", n); end
    if (n >= 3) begin
      checks++; if (got_pc[0] !== 32'h0 || got_pc[1] !== 32'h4 || got_pc[2] !== 32'h8)
        begin failures++; $display("FAIL bp_order got=%h,%h,%h exp=0,4,8", got_pc[0], got_pc[1], got_pc[2]); end
      checks++; if (got_in[0] !== I0 || got_in[1] !== I1 || got_in[2] !== I2)
        begin failures++; $display("FAIL bp_instr got=%h,%h,%h exp=%h,%h,%h", got_in[0], got_in[1], got_in[2], I0, I1, I2); end
    end
  endtask

  task automatic test_redirect();
    out_ready = 1'b0;
    do_reset();
    for (int c = 0; c < 6; c++) step();
    redirect_to(32'h12);
    checks++; if (out_valid !== 1'b0 || imem_addr !== 32'h10)
      begin failures++; $display("FAIL redir_flush got=%b/%h exp=0/10", out_valid, imem_addr); end
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h10 || out_instr !== I_AT_10 || out_pc_plus4 !== 32'h14)
      begin failures++; $display("FAIL redir_entry got=%b/%h/%h/%h exp=1/10/%h/14", out_valid, out_pc, out_instr, out_pc_plus4, I_AT_10); end
  endtask

  task automatic test_wrap();
    out_ready = 1'b0;
    redirect_to(32'hFFFF_FFFC);
    checks++; if (imem_addr !== 32'hFFFF_FFFC || out_valid !== 1'b0)
      begin failures++; $display("FAIL wrap_addr got=%h/%b exp=fffffffc/0", imem_addr, out_valid); end
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'hFFFF_FFFC || out_instr !== I_TOP || out_pc_plus4 !== 32'h0 || imem_addr !== 32'h0)
      begin failures++; $display("FAIL wrap_entry got=%b/%h/%h/%h/%h exp=1/fffffffc/%h/0/0", out_valid, out_pc, out_instr, out_pc_plus4, imem_addr, I_TOP); end
  endtask

  task automatic test_bounds();
    out_ready = 1'b0;
    redirect_to(32'h100);
    step();
`ifdef FETCH_BOUNDS_CHECK_EN
    checks++; if (fault !== 1'b1 || halted !== 1'b1 || out_valid !== 1'b0)
      begin failures++; $display("FAIL bounds_fault got=%b/%b/%b exp=1/1/0", fault, halted, out_valid); end
`else
    checks++; if (fault !== 1'b0 || halted !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h100 || out_instr !== I0)
      begin failures++; $display("FAIL bounds_alias got=%b/%b/%b/%h/%h exp=0/0/1/100/%h", fault, halted, out_valid, out_pc, out_instr, I0); end
`endif
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    redirect_to(32'h0);
    step();
    step();
    checks++; if (out_valid !== 1'b1)
      begin failures++; $display("FAIL mid_pre_valid got=%b exp=1", out_valid); end
    #3;
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || halted !== 1'b0 || fault !== 1'b0 || imem_addr !== 32'h0)
      begin failures++; $display("FAIL mid_reset_ctrl got=%b/%b/%b/%h exp=0/0/0/0", out_valid, halted, fault, imem_addr); end
    checks++; if ({out_pc, out_instr, out_pc_plus4} !== 96'h0)
      begin failures++; $display("FAIL mid_reset_head got=%h/%h/%h exp=0", out_pc, out_instr, out_pc_plus4); end
    step();
    reset = 1'b0;
  endtask

  initial begin
    load_program();
    test_reset();
    test_stream();
    test_halt_redirect();
    test_backpressure();
    test_redirect();
`ifndef FETCH_BOUNDS_CHECK_EN
    test_wrap();
`endif
    test_bounds();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
